fetch_unit: RTL and testbench

//  - Instruction fetch stage feeding the decoder: owns the PC and issues reads to a synchronous 1-cycle-latency instruction memory.
//  - Buffers returned words with their PC in a small FIFO and presents them on a valid/ready interface (instruction, pc).
//  - Accepts redirects from the branch unit, which flush all buffered and in-flight fetches.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle imem read, credit-controlled output FIFO with redirect flush.
// Optional FETCH_STALL_CNT_EN adds o_stall_cycles, counting decoder-ready cycles with nothing to deliver.
module fetch_unit #(
    parameter int                PC_W     = 9,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] o_instruction,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_valid,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0]        o_stall_cycles,
`endif
    input  logic               i_ready
);
    localparam int CW = $clog2(DEPTH);

    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    captured_pc;
    logic               inflight;
    logic [CW:0]        count;
    logic [CW-1:0]      rd_ptr;
    logic [CW-1:0]      wr_ptr;
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]    mem_pc    [DEPTH];

    logic               pop;
    logic               push;
    logic               issue;
    logic [CW+1:0]      need;

    assign o_valid       = (count != '0);
    assign o_instruction = mem_instr[rd_ptr];
    assign o_pc          = mem_pc[rd_ptr];

    assign pop  = o_valid & i_ready;
    assign push = inflight & ~redirect_valid;

    // Credits include the word in flight, so a push can never land on a full FIFO.
    assign need  = {1'b0, count} + (CW+2)'(inflight) - (CW+2)'(pop);
    assign issue = ~redirect_valid & (need < (CW+2)'(DEPTH));

    assign imem_en   = issue;
    assign imem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            captured_pc <= RESET_PC;
            inflight    <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            pc_q     <= redirect_pc & ~PC_W'(3);
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (issue) begin
                pc_q        <= pc_q + PC_W'(4);
                captured_pc <= pc_q;
                inflight    <= 1'b1;
            end else begin
                inflight <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= captured_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            assert (count < (CW+1)'(DEPTH))
            else $error("fetch_unit: push into full FIFO");
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_stall_cycles <= '0;
        end else if (i_ready && !o_valid) begin
            o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table plus random traffic against a queue-based model.
// Define FETCH_STALL_CNT_EN for both files to also check o_stall_cycles.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [8:0]  redirect_pc = '0;
    logic        imem_en;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] o_instruction;
    logic [8:0]  o_pc;
    logic        o_valid;
    logic        i_ready = 1'b0;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] o_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .o_instruction(o_instruction), .o_pc(o_pc), .o_valid(o_valid),
`ifdef FETCH_STALL_CNT_EN
        .o_stall_cycles(o_stall_cycles),
`endif
        .i_ready(i_ready)
    );

    always #5 clk = ~clk;

    // Address 0x010 holds a NOP-encoded word to show it passes through untouched.
    function automatic logic [31:0] tag(input logic [8:0] a);
        if (a == 9'h010) return 32'h0000_0013;
        return {16'hBEEF, 7'h00, a};
    endfunction

    always @(posedge clk) if (imem_en) imem_rdata <= tag(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered PCs in a queue, one outstanding fetch, expected output stream PC.
    logic [8:0]  m_q[$];
    logic [8:0]  m_pc = '0;
    logic [8:0]  m_cap = '0;
    bit          m_infl = 0;
    logic [8:0]  m_next_out = '0;
    logic [31:0] m_stall = '0;

    task automatic cycle(input bit rst, input bit rv, input logic [8:0] rpc, input bit rdy, input bit chk_en);
        bit ev, pop, iss;
        @(posedge clk);
        #1;
        reset = rst; redirect_valid = rv; redirect_pc = rpc; i_ready = rdy;
        #4;
        ev  = (m_q.size() > 0);
        pop = ev && rdy;
        iss = !rv && ((m_q.size() + int'(m_infl) - int'(pop)) < 4);
        if (chk_en) begin
            chk("mdl_valid", 32'(o_valid), 32'(ev));
            chk("mdl_imem_en", 32'(imem_en), 32'(iss));
            chk("mdl_imem_addr", 32'(imem_addr), 32'(m_pc));
            if (ev) begin
                chk("mdl_o_pc", 32'(o_pc), 32'(m_q[0]));
                chk("mdl_instr", o_instruction, tag(m_q[0]));
            end
            if (pop) chk("stream_pc", 32'(o_pc), 32'(m_next_out));
`ifdef FETCH_STALL_CNT_EN
            chk("stall_cnt", o_stall_cycles, m_stall);
`endif
        end
        if (rst) begin
            m_q.delete(); m_pc = 9'h000; m_infl = 0; m_next_out = 9'h000; m_stall = 0;
        end else begin
            if (rdy && !ev) m_stall++;
            if (rv) begin
                m_q.delete(); m_infl = 0;
                m_pc = rpc & 9'h1FC; m_next_out = m_pc;
            end else begin
                if (pop) begin
                    void'(m_q.pop_front());
                    m_next_out = m_next_out + 9'd4;
                end
                if (m_infl) m_q.push_back(m_cap);
                if (iss) begin
                    m_cap = m_pc; m_pc = m_pc + 9'd4; m_infl = 1;
                end else begin
                    m_infl = 0;
                end
            end
            if (chk_en) chk("mdl_depth", 32'(m_q.size() <= 4), 32'd1);
        end
    endtask

    typedef struct {
        bit         rst;
        bit         rv;
        logic [8:0] rpc;
        bit         rdy;
        bit         e_valid;
        logic [8:0] e_pc;
        bit         e_en;
        logic [8:0] e_addr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit rst, bit rv, logic [8:0] rpc, bit rdy,
                                bit ev, logic [8:0] epc, bit en, logic [8:0] ea);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_en = en; v.e_addr = ea;
        return v;
    endfunction

    initial begin
        // Startup stream
        vt.push_back(mk(0,0,0,1, 0,9'h000, 1,9'h000));
        vt.push_back(mk(0,0,0,1, 0,9'h000, 1,9'h004));
        vt.push_back(mk(0,0,0,1, 1,9'h000, 1,9'h008));
        vt.push_back(mk(0,0,0,1, 1,9'h004, 1,9'h00C));
        // Decoder stall: fetch stops at four credits, resumes gap-free
        vt.push_back(mk(0,0,0,0, 1,9'h008, 1,9'h010));
        vt.push_back(mk(0,0,0,0, 1,9'h008, 1,9'h014));
        vt.push_back(mk(0,0,0,0, 1,9'h008, 0,9'h018));
        vt.push_back(mk(0,0,0,0, 1,9'h008, 0,9'h018));
        vt.push_back(mk(0,0,0,1, 1,9'h008, 1,9'h018));
        vt.push_back(mk(0,0,0,1, 1,9'h00C, 1,9'h01C));
        // Redirect to 0x103 with credits exhausted
        vt.push_back(mk(0,1,9'h103,1, 1,9'h010, 0,9'h020));
        vt.push_back(mk(0,0,0,1, 0,9'h000, 1,9'h100));
        vt.push_back(mk(0,0,0,1, 0,9'h000, 1,9'h104));
        vt.push_back(mk(0,0,0,1, 1,9'h100, 1,9'h108));
        // PC wrap
        vt.push_back(mk(0,1,9'h1F8,1, 1,9'h104, 0,9'h10C));
        vt.push_back(mk(0,0,0,1, 0,9'h000, 1,9'h1F8));
        vt.push_back(mk(0,0,0,1, 0,9'h000, 1,9'h1FC));
        vt.push_back(mk(0,0,0,1, 1,9'h1F8, 1,9'h000));
        vt.push_back(mk(0,0,0,1, 1,9'h1FC, 1,9'h004));
        vt.push_back(mk(0,0,0,1, 1,9'h000, 1,9'h008));
        vt.push_back(mk(0,0,0,1, 1,9'h004, 1,9'h00C));
        // Reset with three buffered entries and one in flight
        vt.push_back(mk(0,0,0,0, 1,9'h008, 1,9'h010));
        vt.push_back(mk(0,0,0,0, 1,9'h008, 1,9'h014));
        vt.push_back(mk(1,0,0,0, 1,9'h008, 0,9'h018));
        vt.push_back(mk(0,0,0,1, 0,9'h000, 1,9'h000));
        vt.push_back(mk(0,0,0,1, 0,9'h000, 1,9'h004));
        vt.push_back(mk(0,0,0,1, 1,9'h000, 1,9'h008));

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].rst, vt[i].rv, vt[i].rpc, vt[i].rdy, 1);
            chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d_en", i), 32'(imem_en), 32'(vt[i].e_en));
            chk($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vt[i].e_addr));
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_pc", i), 32'(o_pc), 32'(vt[i].e_pc));
                chk($sformatf("vec%0d_instr", i), o_instruction, tag(vt[i].e_pc));
            end
        end

        // Held redirect: 4 empty redirect cycles after the first plus 2 refill bubbles
        for (int i = 0; i < 5; i++) cycle(0, 1, 9'h040, 1, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        chk("redir_hold_empty", 32'(o_valid), 32'd0);
        cycle(0, 0, 0, 1, 1);
        chk("redir_hold_valid", 32'(o_valid), 32'd1);
        chk("redir_hold_pc", 32'(o_pc), 32'h040);

        for (int i = 0; i < 3000; i++) begin
            bit         r_rst, r_rv, r_rdy;
            logic [8:0] r_pc;
            r_rst = ($urandom_range(0, 199) == 0);
            r_rv  = ($urandom_range(0, 19) == 0);
            r_pc  = 9'($urandom_range(0, 511));
            r_rdy = ($urandom_range(0, 3) != 0);
            if (i % 400 >= 380) r_rdy = 1'b0;
            cycle(r_rst, r_rv, r_pc, r_rdy, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end
endmodule
